// File: rtl/sysx_slave.sv
// sysX bus slave: synchronizes the master's bus clock, select and data lanes,
// decodes a command byte plus four data bytes and bridges them onto a local register port.
module sysx_slave #(
   parameter logic [1:0] pSelect = 2'd1
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iBusClock,
   input  logic [1:0]  iBusSelect,
   input  logic [7:0]  iBusMOSI,
   output logic [7:0]  oBusMISO,
   output logic        oBusInterrupt,
   output logic [6:0]  oRegAddr,
   output logic [31:0] oRegData,
   output logic        oRegWrite,
   output logic        oRegRead,
   input  logic [31:0] iRegData,
   input  logic        iIntRequest
);

   typedef enum logic [1:0] {ST_IDLE, ST_COMMAND, ST_DATA, ST_END} state_t;
   localparam logic [6:0] STATUS_IDX = 7'h7F;

   state_t      state_reg, state_next;
   logic        bclk_meta_reg, bclk_sync_reg, bclk_prev_reg;
   logic [1:0]  sel_meta_reg, sel_sync_reg;
   logic [7:0]  mosi_meta_reg, mosi_sync_reg;
   logic        selected, bus_rise;
   logic        capture, data_rise, last_rise;
   logic        is_write_reg;
   logic [6:0]  idx_reg;
   logic [1:0]  count_reg;
   logic [31:0] shift_reg;
   logic        load_reg, write_go_reg, clear_go_reg;
   logic [7:0]  miso_next;

   // The bus clock is delayed one extra stage so a rise is seen as 1-after-0.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         bclk_meta_reg <= 1'b0;
         bclk_sync_reg <= 1'b0;
         bclk_prev_reg <= 1'b0;
         sel_meta_reg  <= 2'd0;
         sel_sync_reg  <= 2'd0;
         mosi_meta_reg <= 8'd0;
         mosi_sync_reg <= 8'd0;
      end else begin
         bclk_meta_reg <= iBusClock;
         bclk_sync_reg <= bclk_meta_reg;
         bclk_prev_reg <= bclk_sync_reg;
         sel_meta_reg  <= iBusSelect;
         sel_sync_reg  <= sel_meta_reg;
         mosi_meta_reg <= iBusMOSI;
         mosi_sync_reg <= mosi_meta_reg;
      end
   end

   assign bus_rise = bclk_sync_reg & ~bclk_prev_reg;
   assign selected = (pSelect != 2'd0) && (sel_sync_reg == pSelect);

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      data_rise  = 1'b0;
      last_rise  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (selected) state_next = ST_COMMAND;
         end
         ST_COMMAND: begin
            if (!selected) begin
               state_next = ST_IDLE;
            end else if (bus_rise) begin
               capture    = 1'b1;
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!selected) begin
               state_next = ST_IDLE;
            end else if (bus_rise) begin
               data_rise = 1'b1;
               if (count_reg == 2'd3) begin
                  last_rise  = 1'b1;
                  state_next = ST_END;
               end
            end
         end
         default: begin
            if (!selected) state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      miso_next = 8'hFF;
      if (state_reg == ST_DATA && !is_write_reg) begin
         case (count_reg)
            2'd0:    miso_next = shift_reg[31:24];
            2'd1:    miso_next = shift_reg[23:16];
            2'd2:    miso_next = shift_reg[15:8];
            default: miso_next = shift_reg[7:0];
         endcase
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         is_write_reg  <= 1'b0;
         idx_reg       <= 7'd0;
         count_reg     <= 2'd0;
         shift_reg     <= 32'd0;
         load_reg      <= 1'b0;
         write_go_reg  <= 1'b0;
         clear_go_reg  <= 1'b0;
         oRegRead      <= 1'b0;
         oRegWrite     <= 1'b0;
         oRegAddr      <= 7'd0;
         oRegData      <= 32'd0;
         oBusInterrupt <= 1'b0;
         oBusMISO      <= 8'hFF;
      end else begin
         oRegRead      <= 1'b0;
         load_reg      <= oRegRead;
         write_go_reg  <= last_rise && is_write_reg && (idx_reg != STATUS_IDX);
         clear_go_reg  <= last_rise && is_write_reg && (idx_reg == STATUS_IDX);
         oRegWrite     <= write_go_reg;
         // A new request wins over a status-register clear in the same cycle.
         oBusInterrupt <= iIntRequest | (oBusInterrupt & ~clear_go_reg);
         oBusMISO      <= miso_next;

         if (write_go_reg) begin
            oRegAddr <= idx_reg;
            oRegData <= shift_reg;
         end

         if (capture) begin
            is_write_reg <= mosi_sync_reg[7];
            idx_reg      <= mosi_sync_reg[6:0];
            count_reg    <= 2'd0;
            if (!mosi_sync_reg[7]) begin
               if (mosi_sync_reg[6:0] == STATUS_IDX) begin
                  shift_reg <= {31'd0, oBusInterrupt};
               end else begin
                  oRegRead <= 1'b1;
                  oRegAddr <= mosi_sync_reg[6:0];
               end
            end
         end

         if (load_reg) shift_reg <= iRegData;

         if (data_rise) begin
            count_reg <= count_reg + 2'd1;
            if (is_write_reg) shift_reg <= {shift_reg[23:0], mosi_sync_reg};
         end
      end
   end

endmodule

// File: tb/tb_sysx_slave.sv
// Randomized scoreboard bench for sysx_slave: a bus-master task issues transactions,
// a reference model queues expected strobes and MISO bytes, a monitor compares them.
module tb_sysx_slave;
   localparam int H = 8;

   logic        iClock = 1'b0;
   logic        iReset = 1'b1;
   logic        iBusClock = 1'b0;
   logic [1:0]  iBusSelect = 2'd0;
   logic [7:0]  iBusMOSI = 8'd0;
   logic [7:0]  oBusMISO;
   logic        oBusInterrupt;
   logic [6:0]  oRegAddr;
   logic [31:0] oRegData;
   logic        oRegWrite;
   logic        oRegRead;
   logic [31:0] iRegData = 32'd0;
   logic        iIntRequest = 1'b0;

   sysx_slave #(.pSelect(2'd1)) dut (
      .iClock(iClock), .iReset(iReset), .iBusClock(iBusClock), .iBusSelect(iBusSelect),
      .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO), .oBusInterrupt(oBusInterrupt),
      .oRegAddr(oRegAddr), .oRegData(oRegData), .oRegWrite(oRegWrite), .oRegRead(oRegRead),
      .iRegData(iRegData), .iIntRequest(iIntRequest)
   );

   always #5 iClock = ~iClock;

   typedef struct packed {logic [6:0] addr; logic [31:0] data;} wr_t;
   wr_t         exp_wr_q[$];
   logic [6:0]  exp_rd_q[$];
   logic [7:0]  exp_miso_q[$];
   logic [7:0]  got_miso_q[$];
   logic [31:0] exp_mem    [0:127];
   logic [31:0] periph_mem [0:127];
   bit          model_pending = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Monitor: local-port strobes and sampled MISO bytes against the expected queues.
   initial begin
      wr_t        w;
      logic [6:0] a;
      logic [7:0] e, g;
      forever begin
         @(negedge iClock);
         if (oRegRead) begin
            if (exp_rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read addr %h want no strobe", oRegAddr);
            end else begin
               a = exp_rd_q.pop_front();
               check("read_addr", {25'd0, oRegAddr}, {25'd0, a});
            end
            iRegData = periph_mem[oRegAddr];
         end
         if (oRegWrite) begin
            if (exp_wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write addr %h data %h want no strobe", oRegAddr, oRegData);
            end else begin
               w = exp_wr_q.pop_front();
               check("write_addr", {25'd0, oRegAddr}, {25'd0, w.addr});
               check("write_data", oRegData, w.data);
            end
            periph_mem[oRegAddr] = oRegData;
         end
         while (got_miso_q.size() > 0) begin
            g = got_miso_q.pop_front();
            if (exp_miso_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL miso_unexpected got %h want none", g);
            end else begin
               e = exp_miso_q.pop_front();
               check("miso_byte", {24'd0, g}, {24'd0, e});
            end
         end
      end
   end

   task automatic bus_byte(input logic [7:0] b, input bit chk, input logic [7:0] want);
      @(negedge iClock);
      iBusMOSI = b;
      repeat (H) @(negedge iClock);
      if (chk) begin
         exp_miso_q.push_back(want);
         got_miso_q.push_back(oBusMISO);
      end
      iBusClock = 1'b1;
      repeat (H) @(negedge iClock);
      iBusClock = 1'b0;
   endtask

   // One transaction: command byte then ndata data bytes; ndata < 4 aborts by deselect.
   task automatic xfer(input logic [1:0] sel, input logic [7:0] cmd, input logic [31:0] wdata,
                       input int ndata);
      bit          hit, rd;
      logic [6:0]  idx;
      logic [31:0] rdval;
      logic [7:0]  b, want;
      hit   = (sel == 2'd1);
      rd    = !cmd[7];
      idx   = cmd[6:0];
      rdval = (idx == 7'h7F) ? {31'd0, model_pending} : exp_mem[idx];
      if (hit && rd && idx != 7'h7F) exp_rd_q.push_back(idx);
      if (hit && !rd && ndata == 4) begin
         if (idx != 7'h7F) begin
            exp_wr_q.push_back({idx, wdata});
            exp_mem[idx] = wdata;
         end else begin
            model_pending = 1'b0;
         end
      end
      iBusSelect = sel;
      repeat (4) @(negedge iClock);
      bus_byte(cmd, 1'b1, 8'hFF);
      for (int i = 0; i < ndata; i++) begin
         b    = wdata[31-8*i -: 8];
         want = rdval[31-8*i -: 8];
         if (!hit) bus_byte(b, 1'b1, 8'hFF);
         else      bus_byte(b, rd, want);
      end
      if (ndata == 4) begin
         repeat (2*H) @(negedge iClock);
         exp_miso_q.push_back(8'hFF);
         got_miso_q.push_back(oBusMISO);
      end
      iBusSelect = 2'd0;
      repeat (6) @(negedge iClock);
      $display("xfer sel=%0d cmd=%h data=%h bytes=%0d", sel, cmd, wdata, ndata);
   endtask

   task automatic int_pulse();
      @(negedge iClock);
      iIntRequest = 1'b1;
      @(negedge iClock);
      iIntRequest = 1'b0;
      model_pending = 1'b1;
      @(negedge iClock);
      check("irq_set", {31'd0, oBusInterrupt}, {31'd0, model_pending});
      $display("int pulse");
   endtask

   task automatic check_reset_outputs();
      check("rst_miso", {24'd0, oBusMISO}, 32'h0000_00FF);
      check("rst_irq", {31'd0, oBusInterrupt}, 32'd0);
      check("rst_wr", {31'd0, oRegWrite}, 32'd0);
      check("rst_rd", {31'd0, oRegRead}, 32'd0);
      check("rst_addr", {25'd0, oRegAddr}, 32'd0);
      check("rst_data", oRegData, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [6:0]  a;
      int          op;
      for (int i = 0; i < 128; i++) begin
         d = $urandom;
         exp_mem[i] = d;
         periph_mem[i] = d;
      end
      repeat (3) @(negedge iClock);
      #1 check_reset_outputs();
      @(negedge iClock);
      iReset = 1'b0;
      repeat (4) @(negedge iClock);

      xfer(2'd1, 8'h85, 32'hDEADBEEF, 4);
      exp_mem[3] = 32'h12345678;
      periph_mem[3] = 32'h12345678;
      xfer(2'd1, 8'h03, $urandom, 4);
      xfer(2'd1, 8'h86, 32'hCAFEF00D, 2);
      xfer(2'd1, 8'h86, 32'h01234567, 4);
      xfer(2'd1, 8'h06, 32'd0, 4);

      int_pulse();
      xfer(2'd1, 8'h7F, $urandom, 4);
      xfer(2'd1, 8'hFF, $urandom, 4);
      check("irq_cleared", {31'd0, oBusInterrupt}, {31'd0, model_pending});
      xfer(2'd1, 8'h7F, $urandom, 4);
      iIntRequest = 1'b1;
      xfer(2'd1, 8'hFF, $urandom, 4);
      model_pending = 1'b1;
      iIntRequest = 1'b0;
      check("irq_coincident", {31'd0, oBusInterrupt}, {31'd0, model_pending});

      xfer(2'd2, 8'h85, $urandom, 4);
      xfer(2'd2, 8'h03, $urandom, 4);

      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 6);
         a  = 7'($urandom_range(0, 7));
         case (op)
            0: xfer(2'd1, {1'b1, a}, $urandom, 4);
            1: xfer(2'd1, {1'b0, a}, $urandom, 4);
            2: xfer(2'd1, 8'h7F, $urandom, 4);
            3: int_pulse();
            4: xfer(2'd1, 8'hFF, $urandom, 4);
            5: xfer(2'd1, {$urandom_range(0, 1) == 1, a}, $urandom, 2);
            default: xfer(2'd2, {$urandom_range(0, 1) == 1, a}, $urandom, 4);
         endcase
         check("irq_level", {31'd0, oBusInterrupt}, {31'd0, model_pending});
      end

      // Reset in the middle of a read, after two data bytes.
      int_pulse();
      exp_rd_q.push_back(7'h02);
      iBusSelect = 2'd1;
      repeat (4) @(negedge iClock);
      bus_byte(8'h02, 1'b1, 8'hFF);
      bus_byte(8'h00, 1'b1, exp_mem[2][31:24]);
      bus_byte(8'h00, 1'b1, exp_mem[2][23:16]);
      @(negedge iClock);
      iReset = 1'b1;
      #1 check_reset_outputs();
      model_pending = 1'b0;
      iBusSelect = 2'd0;
      repeat (3) @(negedge iClock);
      iReset = 1'b0;
      repeat (30) @(negedge iClock);
      $display("reset mid-read");
      xfer(2'd1, 8'h84, 32'h5A5AA5A5, 4);
      xfer(2'd1, 8'h04, 32'd0, 4);

      repeat (20) @(negedge iClock);
      check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
      check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
      check("miso_queue_empty", 32'(exp_miso_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
